ex_muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage. It consumes operands and the M-extension function code from the ID/EX pipeline register. It computes one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU result at a time using a radix-2 sequential datapath. While an operation is in flight it drives BUSY, which the pipeline ORs into its stall (BUSY_WAIT) network.

---
 rtl/ex_muldiv_unit_if.sv | 22 ++
 rtl/ex_muldiv_unit.sv | 166 ++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_unit_if.sv
// Request/response bundle between the ID/EX pipeline register and the RV32M mul/div unit.
// The pipeline drives the request as master; the unit answers with BUSY/DONE/RESULT as slave.
interface ex_muldiv_unit_if;
  logic        START;
  logic [2:0]  FUNCT3;
  logic [31:0] OPERAND_A;
  logic [31:0] OPERAND_B;
  logic        KILL;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;

  modport master (
    output START, FUNCT3, OPERAND_A, OPERAND_B, KILL,
    input  BUSY, DONE, RESULT
  );

  modport slave (
    input  START, FUNCT3, OPERAND_A, OPERAND_B, KILL,
    output BUSY, DONE, RESULT
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Radix-2 sequential RV32M multiply/divide; 34 cycles start-to-DONE (1 for div-by-zero/overflow).
// No backpressure: BUSY stalls the pipeline, START outside IDLE is ignored, KILL abandons the op.
module ex_muldiv_unit (
  input logic              CLK,
  input logic              RESET,
  ex_muldiv_unit_if.slave  md
);
  localparam int XLEN = 32;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIXUP, ST_DONE} state_t;

  state_t            state, state_nxt;
  logic [5:0]        cnt;
  logic [2*XLEN-1:0] acc;        // {hi, lo}: product, or {remainder, dividend/quotient}
  logic [XLEN-1:0]   opnd;       // multiplicand or divisor magnitude
  logic [2:0]        f3_q;
  logic              neg_hi;     // product / quotient must be negated
  logic              neg_lo;     // remainder must be negated
  logic [XLEN-1:0]   res_stage;
  logic [XLEN-1:0]   result_q;
  logic              busy_q;
  logic              done_q;

  logic              is_div, sgn_a, sgn_b, neg_a, neg_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf, special, accept;
  logic [XLEN-1:0]   special_res;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, prod;
  logic [XLEN-1:0]   quo, rem, fix_res;

  // Operand decode and magnitude conversion at acceptance
  always_comb begin
    is_div      = md.FUNCT3[2];
    sgn_a       = is_div ? ~md.FUNCT3[0] : (md.FUNCT3 != 3'd3);
    sgn_b       = is_div ? ~md.FUNCT3[0] : ~md.FUNCT3[1];
    neg_a       = sgn_a & md.OPERAND_A[XLEN-1];
    neg_b       = sgn_b & md.OPERAND_B[XLEN-1];
    mag_a       = neg_a ? (32'd0 - md.OPERAND_A) : md.OPERAND_A;
    mag_b       = neg_b ? (32'd0 - md.OPERAND_B) : md.OPERAND_B;
    div_zero    = is_div && (md.OPERAND_B == 32'd0);
    div_ovf     = is_div && !md.FUNCT3[0] && (md.OPERAND_A == 32'h8000_0000)
                  && (md.OPERAND_B == 32'hFFFF_FFFF);
    special     = div_zero | div_ovf;
    special_res = 32'd0;
    if (div_zero)
      special_res = md.FUNCT3[1] ? md.OPERAND_A : 32'hFFFF_FFFF;
    else
      special_res = md.FUNCT3[1] ? 32'd0 : 32'h8000_0000;
    accept      = (state == ST_IDLE) && md.START && !md.KILL;
  end

  // One iteration step for each operation class
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    mul_nxt   = {mul_sum, acc[XLEN-1:1]};
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (div_diff[XLEN])
      div_nxt = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      div_nxt = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  // Sign correction and result selection
  always_comb begin
    prod    = neg_hi ? (64'd0 - acc) : acc;
    quo     = neg_hi ? (32'd0 - acc[XLEN-1:0]) : acc[XLEN-1:0];
    rem     = neg_lo ? (32'd0 - acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
    fix_res = 32'd0;
    case (f3_q)
      3'd0:                fix_res = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    fix_res = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:          fix_res = quo;
      default:             fix_res = rem;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept)
          state_nxt = special ? ST_DONE : ST_CALC;
      end
      ST_CALC: begin
        if (md.KILL)
          state_nxt = ST_IDLE;
        else if (cnt == 6'd1)
          state_nxt = ST_FIXUP;
      end
      ST_FIXUP: begin
        state_nxt = md.KILL ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt       <= 6'd0;
      acc       <= 64'd0;
      opnd      <= 32'd0;
      f3_q      <= 3'd0;
      neg_hi    <= 1'b0;
      neg_lo    <= 1'b0;
      res_stage <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            f3_q   <= md.FUNCT3;
            neg_hi <= neg_a ^ neg_b;
            neg_lo <= neg_a;
            cnt    <= 6'd32;
            if (is_div) begin
              acc  <= {32'd0, mag_a};
              opnd <= mag_b;
            end else begin
              acc  <= {32'd0, mag_b};
              opnd <= mag_a;
            end
            if (special)
              res_stage <= special_res;
          end
        end
        ST_CALC: begin
          cnt <= cnt - 6'd1;
          acc <= f3_q[2] ? div_nxt : mul_nxt;
        end
        ST_FIXUP: res_stage <= fix_res;
        default: ;
      endcase
    end
  end

  // RESULT only moves together with a DONE pulse, so a late KILL leaves it untouched
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      busy_q <= (state_nxt == ST_CALC) || (state_nxt == ST_FIXUP)
                || ((state_nxt == ST_DONE) && (state != ST_IDLE));
      done_q <= (state == ST_DONE) && !md.KILL;
      if ((state == ST_DONE) && !md.KILL)
        result_q <= res_stage;
    end
  end

  assign md.BUSY   = busy_q;
  assign md.DONE   = done_q;
  assign md.RESULT = result_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed RV32M cases, flush/hazard cases and random ops
// compared against an arithmetic reference model.
module tb_ex_muldiv_unit;
  logic CLK = 1'b0;
  logic RESET;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] last_res;

  always #5 CLK = ~CLK;

  ex_muldiv_unit_if md_if ();

  ex_muldiv_unit dut (
    .CLK   (CLK),
    .RESET (RESET),
    .md    (md_if)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'd0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      default: begin
        if (b == 32'd0)
          return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return f3[1] ? 32'd0 : 32'h8000_0000;
        if (!f3[0])
          p = f3[1] ? (sa % sb) : (sa / sb);
        else
          p = f3[1] ? (ua % ub) : (ua / ub);
        return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && ((b == 32'd0) ||
                     (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic drive_req(input logic s, input logic k, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b);
    md_if.START     = s;
    md_if.KILL      = k;
    md_if.FUNCT3    = f3;
    md_if.OPERAND_A = a;
    md_if.OPERAND_B = b;
  endtask

  // Issue one op, wait (bounded) for DONE, check result, latency, BUSY and pulse width
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_r, got;
    int          exp_lat, lat;
    logic        first_busy, busy_seen;
    exp_r   = model(f3, a, b);
    exp_lat = is_special(f3, a, b) ? 1 : 34;
    lat     = 0;
    got     = 32'hDEAD_BEEF;
    busy_seen = 1'b0;
    @(negedge CLK);
    drive_req(1'b1, 1'b0, f3, a, b);
    @(posedge CLK);
    #1;
    md_if.START = 1'b0;
    first_busy = md_if.BUSY;
    for (int n = 1; n <= 60 && lat == 0; n++) begin
      @(posedge CLK);
      #1;
      if (md_if.DONE) begin
        lat = n;
        got = md_if.RESULT;
      end else if (md_if.BUSY) begin
        busy_seen = 1'b1;
      end
    end
    check({tag, " result"}, got, exp_r);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    if (exp_lat == 1)
      check({tag, " busy never"}, 32'(first_busy | busy_seen), 32'd0);
    else
      check({tag, " busy after start"}, 32'(first_busy), 32'd1);
    @(posedge CLK);
    #1;
    check({tag, " done one cycle"}, 32'(md_if.DONE), 32'd0);
    last_res = exp_r;
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge CLK);
      #1;
      if (md_if.DONE) cnt++;
    end
  endtask

  initial begin
    int          cnt;
    int          d_cyc[2];
    logic [31:0] d_res[2];
    logic [2:0]  rf3;
    logic [31:0] ra, rb;

    RESET = 1'b0;
    drive_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    last_res = 32'd0;
    #12;
    check("reset busy",   32'(md_if.BUSY), 32'd0);
    check("reset done",   32'(md_if.DONE), 32'd0);
    check("reset result", md_if.RESULT,    32'd0);
    @(negedge CLK);
    RESET = 1'b1;

    // High products, signed division, special divides
    do_op("mulh min*min",  3'd1, 32'h8000_0000, 32'h8000_0000);
    do_op("mulhu max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("mulhsu -1*2",   3'd2, 32'hFFFF_FFFF, 32'h0000_0002);
    do_op("div -7/2",      3'd4, 32'hFFFF_FFF9, 32'd2);
    do_op("rem -7/2",      3'd6, 32'hFFFF_FFF9, 32'd2);
    do_op("divu big/2",    3'd5, 32'hFFFF_FFF9, 32'd2);
    do_op("divu 5/0",      3'd5, 32'd5, 32'd0);
    do_op("remu 5/0",      3'd7, 32'd5, 32'd0);
    do_op("div ovf",       3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("rem ovf",       3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("mul 1234*-5",   3'd0, 32'd1234, 32'hFFFF_FFFB);

    // Asynchronous reset in the middle of a divide
    @(negedge CLK);
    drive_req(1'b1, 1'b0, 3'd4, 32'd100, 32'd7);
    @(posedge CLK);
    #1;
    md_if.START = 1'b0;
    repeat (10) @(posedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    check("midreset busy",   32'(md_if.BUSY), 32'd0);
    check("midreset done",   32'(md_if.DONE), 32'd0);
    check("midreset result", md_if.RESULT,    32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    do_op("mul 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD);

    // KILL during CALC
    @(negedge CLK);
    drive_req(1'b1, 1'b0, 3'd0, 32'd3, 32'd5);
    @(posedge CLK);
    #1;
    md_if.START = 1'b0;
    repeat (19) @(posedge CLK);
    @(negedge CLK);
    md_if.KILL = 1'b1;
    @(posedge CLK);
    #1;
    md_if.KILL = 1'b0;
    check("kill busy", 32'(md_if.BUSY), 32'd0);
    count_dones(50, cnt);
    check("kill no done", 32'(cnt), 32'd0);
    check("kill result held", md_if.RESULT, last_res);
    do_op("after kill divu", 3'd5, 32'd1000, 32'd10);

    // START pulsed during CALC is ignored
    @(negedge CLK);
    drive_req(1'b1, 1'b0, 3'd5, 32'd900, 32'd9);
    @(posedge CLK);
    #1;
    md_if.START = 1'b0;
    repeat (9) @(posedge CLK);
    @(negedge CLK);
    drive_req(1'b1, 1'b0, 3'd0, 32'd9, 32'd9);
    @(posedge CLK);
    #1;
    md_if.START = 1'b0;
    cnt = 0;
    d_res[0] = 32'd0;
    for (int n = 0; n < 80; n++) begin
      @(posedge CLK);
      #1;
      if (md_if.DONE) begin
        if (cnt == 0) d_res[0] = md_if.RESULT;
        cnt++;
      end
    end
    check("calc start done count", 32'(cnt), 32'd1);
    check("calc start result", d_res[0], 32'd100);
    last_res = 32'd100;

    // START together with KILL in IDLE is not accepted
    @(negedge CLK);
    drive_req(1'b1, 1'b1, 3'd0, 32'd2, 32'd3);
    @(posedge CLK);
    #1;
    drive_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    check("kill+start busy", 32'(md_if.BUSY), 32'd0);
    count_dones(40, cnt);
    check("kill+start no done", 32'(cnt), 32'd0);
    check("kill+start result", md_if.RESULT, last_res);

    // Back-to-back with START held high
    @(negedge CLK);
    drive_req(1'b1, 1'b0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge CLK);
    #1;
    drive_req(1'b1, 1'b0, 3'd7, 32'd100, 32'd7);
    cnt = 0;
    d_cyc[0] = 0; d_cyc[1] = 0;
    d_res[0] = 32'd0; d_res[1] = 32'd0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge CLK);
      #1;
      if (n == 35) md_if.START = 1'b0;
      if (md_if.DONE) begin
        if (cnt < 2) begin
          d_cyc[cnt] = n;
          d_res[cnt] = md_if.RESULT;
        end
        cnt++;
      end
    end
    check("b2b done count",  32'(cnt),      32'd2);
    check("b2b first cycle", 32'(d_cyc[0]), 32'd34);
    check("b2b first res",   d_res[0],      32'hFFFF_FFFE);
    check("b2b second cycle", 32'(d_cyc[1]), 32'd69);
    check("b2b second res",  d_res[1],      32'd2);

    // Random operations, biased toward divide corner cases
    for (int i = 0; i < 40; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 20));
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      do_op($sformatf("rand%0d f3=%0d", i, rf3), rf3, ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
